// File: rtl/instr_encoder.sv
// instr_encoder
// Program loader: accepts symbolic instructions over a valid/ready handshake,
// encodes each legal one into a 32-bit MIPS word and writes it, one per cycle,
// into the instruction memory write port starting at BASE_PC.
//
// Ports
//   clk, reset        clock and synchronous active-high reset
//   start, finish     session control pulses
//   in_valid/in_ready beat handshake; beat taken when both are high
//   mnem              0 ADDU 1 SUBU 2 JR 3 ORI 4 LW 5 SW 6 BEQ 7 LUI
//                     8 JAL 9 J 10 ADDI 11 JALR, 12-15 illegal
//   rs, rt, rd, imm, target  instruction fields
//   im_we, im_addr, im_wdata instruction memory write port (registered)
//   count             words written this session (saturates at DEPTH)
//   full              count == DEPTH
//   busy              session is loading
//   err               sticky illegal-mnemonic flag, cleared by start or reset
module instr_encoder #(
  parameter int          DEPTH   = 1024,
  parameter logic [31:0] BASE_PC = 32'h0000_3000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     finish,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               mnem,
  input  logic [4:0]               rs,
  input  logic [4:0]               rt,
  input  logic [4:0]               rd,
  input  logic [15:0]              imm,
  input  logic [25:0]              target,
  output logic                     im_we,
  output logic [31:0]              im_addr,
  output logic [31:0]              im_wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     busy,
  output logic                     err
);

  localparam int             CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t      state_q, state_d;
  logic        accept;
  logic        legal;
  logic [31:0] word;

  // Next-state logic. start is only looked at outside LOAD, so start and
  // finish together in IDLE simply enter LOAD.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)  state_d = LOAD;
      LOAD:    if (finish) state_d = DONE;
      DONE:    if (start)  state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  assign full     = (count == DEPTH_C);
  assign busy     = (state_q == LOAD);
  assign in_ready = busy && !full && !finish;
  assign accept   = in_valid && in_ready;

  // Field packing; shamt is always zero and unused register fields are forced
  // to zero so the decoder sees canonical encodings.
  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (mnem)
      4'd0:  word = {6'b000000, rs, rt, rd, 5'd0, 6'b100001};      // ADDU
      4'd1:  word = {6'b000000, rs, rt, rd, 5'd0, 6'b100011};      // SUBU
      4'd2:  word = {6'b000000, rs, 5'd0, 5'd0, 5'd0, 6'b001000};  // JR
      4'd3:  word = {6'b001101, rs, rt, imm};                      // ORI
      4'd4:  word = {6'b100011, rs, rt, imm};                      // LW
      4'd5:  word = {6'b101011, rs, rt, imm};                      // SW
      4'd6:  word = {6'b000100, rs, rt, imm};                      // BEQ
      4'd7:  word = {6'b001111, 5'd0, rt, imm};                    // LUI
      4'd8:  word = {6'b000011, target};                           // JAL
      4'd9:  word = {6'b000010, target};                           // J
      4'd10: word = {6'b001000, rs, rt, imm};                      // ADDI
      4'd11: word = {6'b000000, rs, 5'd0, rd, 5'd0, 6'b001001};    // JALR
      default: legal = 1'b0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count    <= '0;
      err      <= 1'b0;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
    end else begin
      state_q <= state_d;
      im_we   <= 1'b0;
      if (state_q != LOAD && state_d == LOAD) begin
        count <= '0;
        err   <= 1'b0;
      end else if (accept) begin
        if (legal) begin
          // Address uses the count seen at accept; full keeps count <= DEPTH.
          im_we    <= 1'b1;
          im_addr  <= BASE_PC + 32'({count, 2'b00});
          im_wdata <= word;
          count    <= count + CW'(1);
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam int          DEPTH  = 1024;
  localparam int          SDEPTH = 4;
  localparam logic [31:0] BASE   = 32'h0000_3000;

  typedef struct {
    logic [3:0]  mnem;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] target;
  } beat_t;

  logic        clk = 1'b0, reset = 1'b0;
  logic        start = 1'b0, finish = 1'b0, in_valid = 1'b0;
  logic        start2 = 1'b0, finish2 = 1'b0, in_valid2 = 1'b0;
  logic [3:0]  mnem = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0;
  logic [15:0] imm = '0;
  logic [25:0] target = '0;

  logic        in_ready, im_we, full, busy, err;
  logic [31:0] im_addr, im_wdata;
  logic [10:0] count;
  logic        in_ready2, im_we2, full2, busy2, err2;
  logic [31:0] im_addr2, im_wdata2;
  logic [2:0]  count2;

  int vectors = 0, miscompares = 0;

  // reference model state
  int          m_state;  // 0 idle, 1 load, 2 done
  int          m_count;
  logic        m_err, m_we;
  logic [31:0] m_addr, m_wdata;

  instr_encoder #(.DEPTH(DEPTH), .BASE_PC(BASE)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .mnem(mnem), .rs(rs), .rt(rt),
    .rd(rd), .imm(imm), .target(target), .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .count(count), .full(full), .busy(busy), .err(err)
  );

  instr_encoder #(.DEPTH(SDEPTH), .BASE_PC(BASE)) dut_small (
    .clk(clk), .reset(reset), .start(start2), .finish(finish2),
    .in_valid(in_valid2), .in_ready(in_ready2), .mnem(mnem), .rs(rs), .rt(rt),
    .rd(rd), .imm(imm), .target(target), .im_we(im_we2), .im_addr(im_addr2),
    .im_wdata(im_wdata2), .count(count2), .full(full2), .busy(busy2), .err(err2)
  );

  always #5 clk = ~clk;

  function automatic beat_t mk(int m, int s, int t, int d, int i, int g);
    beat_t b;
    b.mnem = 4'(m); b.rs = 5'(s); b.rt = 5'(t); b.rd = 5'(d);
    b.imm = 16'(i); b.target = 26'(g);
    return b;
  endfunction

  // Encoding computed from the opcode/function tables with plain arithmetic.
  function automatic logic [31:0] ref_word(beat_t b);
    int unsigned s, t, d, i, g, w;
    s = b.rs; t = b.rt; d = b.rd; i = b.imm; g = b.target;
    case (b.mnem)
      0:  w = s * (1 << 21) + t * (1 << 16) + d * (1 << 11) + 33;
      1:  w = s * (1 << 21) + t * (1 << 16) + d * (1 << 11) + 35;
      2:  w = s * (1 << 21) + 8;
      11: w = s * (1 << 21) + d * (1 << 11) + 9;
      3:  w = 13 * (1 << 26) + s * (1 << 21) + t * (1 << 16) + i;
      10: w = 8  * (1 << 26) + s * (1 << 21) + t * (1 << 16) + i;
      4:  w = 35 * (1 << 26) + s * (1 << 21) + t * (1 << 16) + i;
      5:  w = 43 * (1 << 26) + s * (1 << 21) + t * (1 << 16) + i;
      6:  w = 4  * (1 << 26) + s * (1 << 21) + t * (1 << 16) + i;
      7:  w = 15 * (1 << 26) + t * (1 << 16) + i;
      8:  w = 3  * (1 << 26) + g;
      9:  w = 2  * (1 << 26) + g;
      default: w = 0;
    endcase
    return w;
  endfunction

  task automatic set_fields(beat_t b);
    mnem = b.mnem; rs = b.rs; rt = b.rt; rd = b.rd; imm = b.imm; target = b.target;
  endtask

  // Drive one cycle of main-DUT inputs (at negedge), report in_ready as seen
  // mid-cycle, and return at the next negedge.
  task automatic tick(input logic s, input logic f, input logic v, input beat_t b,
                      output logic rdy);
    start = s; finish = f; in_valid = v; set_fields(b);
    #1 rdy = in_ready;
    @(negedge clk);
    start = 1'b0; finish = 1'b0; in_valid = 1'b0;
  endtask

  task automatic apply_reset();
    logic r;
    reset = 1'b1;
    tick(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0), r);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++; if (im_we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %0h want 0", im_we); end
    vectors++; if (im_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h want 0", im_addr); end
    vectors++; if (im_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_wdata: got %h want 0", im_wdata); end
    vectors++; if (count !== 11'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
    vectors++; if ({full, busy, err, in_ready} !== 4'b0) begin miscompares++; $display("FAIL reset_flags: got %b want 0000", {full, busy, err, in_ready}); end
    vectors++; if ({im_we2, count2, busy2} !== 5'b0) begin miscompares++; $display("FAIL reset_small: got %b want 00000", {im_we2, count2, busy2}); end
  endtask

  task automatic test_single();
    logic r;
    tick(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0), r);
    tick(1'b0, 1'b0, 1'b1, mk(0, 1, 2, 3, 0, 0), r);
    vectors++; if (r !== 1'b1) begin miscompares++; $display("FAIL single_ready: got %b want 1", r); end
    vectors++; if ({im_we, im_addr, im_wdata} !== {1'b1, 32'h3000, 32'h0022_1821}) begin miscompares++; $display("FAIL single_write: got we=%b addr=%h data=%h want 1 00003000 00221821", im_we, im_addr, im_wdata); end
    vectors++; if (count !== 11'd1) begin miscompares++; $display("FAIL single_count: got %0d want 1", count); end
    tick(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0), r);
    vectors++; if ({im_we, im_addr, im_wdata} !== {1'b0, 32'h3000, 32'h0022_1821}) begin miscompares++; $display("FAIL single_hold: got we=%b addr=%h data=%h want 0 00003000 00221821", im_we, im_addr, im_wdata); end
  endtask

  task automatic test_back_to_back();
    logic r;
    beat_t bs[4];
    logic [31:0] ws[4];
    bs[0] = mk(3, 0, 1, 0, 16'h1234, 0); ws[0] = 32'h3401_1234;
    bs[1] = mk(7, 0, 2, 0, 16'hFFFF, 0); ws[1] = 32'h3C02_FFFF;
    bs[2] = mk(5, 5, 4, 0, 8, 0);        ws[2] = 32'hACA4_0008;
    bs[3] = mk(6, 1, 2, 0, 16'hFFFF, 0); ws[3] = 32'h1022_FFFF;
    tick(1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0), r);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_done: got busy=%b want 0", busy); end
    tick(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0), r);
    vectors++; if ({busy, count} !== {1'b1, 11'd0}) begin miscompares++; $display("FAIL b2b_restart: got busy=%b count=%0d want 1 0", busy, count); end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 1'b1, bs[i], r);
      vectors++; if ({im_we, im_addr, im_wdata} !== {1'b1, BASE + 32'(4 * i), ws[i]}) begin miscompares++; $display("FAIL b2b_word%0d: got we=%b addr=%h data=%h want 1 %h %h", i, im_we, im_addr, im_wdata, BASE + 32'(4 * i), ws[i]); end
    end
  endtask

  task automatic test_jumps();
    logic r;
    beat_t bs[3];
    logic [31:0] ws[3];
    bs[0] = mk(8, 0, 0, 0, 0, 26'h000_0C00); ws[0] = 32'h0C00_0C00;
    bs[1] = mk(2, 31, 0, 0, 0, 0);           ws[1] = 32'h03E0_0008;
    bs[2] = mk(11, 4, 0, 31, 0, 0);          ws[2] = 32'h0080_F809;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 1'b1, bs[i], r);
      vectors++; if ({im_we, im_wdata} !== {1'b1, ws[i]}) begin miscompares++; $display("FAIL jump%0d: got we=%b data=%h want 1 %h", i, im_we, im_wdata, ws[i]); end
    end
  endtask

  task automatic test_illegal();
    logic r;
    tick(1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0), r);
    tick(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0), r);
    tick(1'b0, 1'b0, 1'b1, mk(0, 1, 2, 3, 0, 0), r);
    tick(1'b0, 1'b0, 1'b1, mk(13, 1, 2, 3, 0, 0), r);
    vectors++; if (r !== 1'b1) begin miscompares++; $display("FAIL illegal_taken: got ready=%b want 1", r); end
    vectors++; if ({im_we, err, count} !== {1'b0, 1'b1, 11'd1}) begin miscompares++; $display("FAIL illegal_nowrite: got we=%b err=%b count=%0d want 0 1 1", im_we, err, count); end
    tick(1'b0, 1'b0, 1'b1, mk(1, 4, 5, 6, 0, 0), r);
    vectors++; if ({im_we, im_addr, im_wdata} !== {1'b1, 32'h3004, ref_word(mk(1, 4, 5, 6, 0, 0))}) begin miscompares++; $display("FAIL illegal_next: got we=%b addr=%h data=%h want 1 00003004 %h", im_we, im_addr, im_wdata, ref_word(mk(1, 4, 5, 6, 0, 0))); end
    vectors++; if ({err, count} !== {1'b1, 11'd2}) begin miscompares++; $display("FAIL illegal_sticky: got err=%b count=%0d want 1 2", err, count); end
    tick(1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0), r);
    tick(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0), r);
    vectors++; if ({err, count} !== {1'b0, 11'd0}) begin miscompares++; $display("FAIL illegal_clear: got err=%b count=%0d want 0 0", err, count); end
  endtask

  task automatic test_finish_valid();
    logic r;
    tick(1'b0, 1'b1, 1'b1, mk(3, 1, 1, 0, 5, 0), r);
    vectors++; if (r !== 1'b0) begin miscompares++; $display("FAIL finish_ready: got %b want 0", r); end
    vectors++; if ({im_we, busy, count} !== {1'b0, 1'b0, 11'd0}) begin miscompares++; $display("FAIL finish_state: got we=%b busy=%b count=%0d want 0 0 0", im_we, busy, count); end
    apply_reset();
    tick(1'b1, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0), r);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL start_finish_idle: got busy=%b want 1", busy); end
    tick(1'b0, 1'b0, 1'b1, mk(9, 0, 0, 0, 0, 26'h3FF_FFFF), r);
    tick(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0), r);
    vectors++; if ({busy, count} !== {1'b1, 11'd1}) begin miscompares++; $display("FAIL start_in_load: got busy=%b count=%0d want 1 1", busy, count); end
  endtask

  task automatic test_reset_mid();
    logic r;
    tick(1'b0, 1'b0, 1'b1, mk(4, 2, 3, 0, 16'h0010, 0), r);
    reset = 1'b1;
    tick(1'b0, 1'b0, 1'b1, mk(0, 1, 1, 1, 0, 0), r);
    reset = 1'b0;
    vectors++; if ({im_we, im_addr, im_wdata, count, busy, err, full} !== '0) begin miscompares++; $display("FAIL reset_mid: got we=%b addr=%h data=%h count=%0d busy=%b want all 0", im_we, im_addr, im_wdata, count, busy); end
    tick(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0), r);
    reset = 1'b1;
    tick(1'b0, 1'b0, 1'b1, mk(0, 1, 1, 1, 0, 0), r);
    reset = 1'b0;
    vectors++; if ({im_we, count, busy} !== '0) begin miscompares++; $display("FAIL reset_drop: got we=%b count=%0d busy=%b want 0 0 0", im_we, count, busy); end
  endtask

  task automatic test_full();
    int acc, writes;
    logic took;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    acc = 0; writes = 0;
    for (int c = 0; c < 12; c++) begin
      in_valid2 = (acc < 6);
      set_fields(mk(0, acc, acc + 1, acc + 2, 0, 0));
      #1 took = in_valid2 && in_ready2;
      @(negedge clk);
      if (took) begin
        vectors++; if ({im_we2, im_addr2, im_wdata2} !== {1'b1, BASE + 32'(4 * acc), ref_word(mk(0, acc, acc + 1, acc + 2, 0, 0))}) begin miscompares++; $display("FAIL full_write%0d: got we=%b addr=%h data=%h", acc, im_we2, im_addr2, im_wdata2); end
        acc++;
      end
      if (im_we2) writes++;
    end
    vectors++; if (writes !== 4) begin miscompares++; $display("FAIL full_writes: got %0d want 4", writes); end
    vectors++; if ({full2, in_ready2, count2} !== {1'b1, 1'b0, 3'd4}) begin miscompares++; $display("FAIL full_stall: got full=%b ready=%b count=%0d want 1 0 4", full2, in_ready2, count2); end
    in_valid2 = 1'b0;
  endtask

  task automatic test_random();
    beat_t b;
    logic s, f, v, r, exp_ready, acc;
    apply_reset();
    m_state = 0; m_count = 0; m_err = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    for (int c = 0; c < 400; c++) begin
      s = (c == 0) || ($urandom_range(0, 9) == 0);
      f = ($urandom_range(0, 19) == 0);
      v = ($urandom_range(0, 9) < 7);
      b = mk($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 65535), $urandom);
      exp_ready = (m_state == 1) && (m_count != DEPTH) && !f;
      tick(s, f, v, b, r);
      vectors++; if (r !== exp_ready) begin miscompares++; $display("FAIL rand_ready c%0d: got %b want %b", c, r, exp_ready); end
      acc = v && exp_ready;
      m_we = 1'b0;
      if (acc) begin
        if (b.mnem <= 11) begin
          m_we = 1'b1; m_addr = BASE + 32'(4 * m_count); m_wdata = ref_word(b); m_count++;
        end else m_err = 1'b1;
      end
      if (m_state != 1 && s) begin m_state = 1; m_count = 0; m_err = 1'b0; end
      else if (m_state == 1 && f) m_state = 2;
      vectors++; if ({im_we, im_addr, im_wdata} !== {m_we, m_addr, m_wdata}) begin miscompares++; $display("FAIL rand_write c%0d: got we=%b addr=%h data=%h want %b %h %h", c, im_we, im_addr, im_wdata, m_we, m_addr, m_wdata); end
      vectors++; if ({count, err, busy, full} !== {11'(m_count), m_err, m_state == 1, m_count == DEPTH}) begin miscompares++; $display("FAIL rand_status c%0d: got count=%0d err=%b busy=%b want %0d %b %b", c, count, err, busy, m_count, m_err, m_state == 1); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_jumps();
    test_illegal();
    test_finish_valid();
    test_reset_mid();
    test_full();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Program loader that is the inverse of the P5 control decoder. It accepts symbolic instructions (mnemonic code plus register, immediate and target fields) over a valid/ready handshake and encodes each one into a 32-bit MIPS word with the op/func values the decoder expects. It writes the words one per cycle into the instruction memory write port, starting at the reset PC. The bench and the self-test harness use it to build programs for the pipelined core.

## Interface
Parameters:
- DEPTH, 1024: capacity in words.
- BASE_PC, 32'h00003000: byte address of the first written word.

Ports:
- clk  in  1  clock.
- reset  in  1  one clock; reset is synchronous and active-high.
- start  in  1  pulse; begins a new load session.
- finish  in  1  pulse; ends the session.
- in_valid  in  1  beat offered.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- mnem  in  4  0 ADDU, 1 SUBU, 2 JR, 3 ORI, 4 LW, 5 SW, 6 BEQ, 7 LUI, 8 JAL, 9 J, 10 ADDI, 11 JALR, 12-15 illegal.
- rs, rt, rd  in  5 each  register fields.
- imm  in  16  immediate or branch offset, passed through unmodified.
- target  in  26  jump target field.
- im_we  out  1  instruction memory write strobe.
- im_addr  out  32  byte address of the write.
- im_wdata  out  32  encoded word.
- count  out  $clog2(DEPTH)+1  words written this session.
- full  out  1  count == DEPTH.
- busy  out  1  state == LOAD.
- err  out  1  sticky; an illegal mnemonic was received.

## Operation
States are IDLE, LOAD and DONE.

State transitions:
- IDLE: start -> LOAD.
- LOAD: finish -> DONE.
- DONE: start -> LOAD.
- start while in LOAD is ignored.

Entering LOAD clears count and err.

in_ready = (state == LOAD) && !full && !finish.

Encoding rules (shamt always 0):
- ADDU: op 000000, rs/rt/rd, func 100001.
- SUBU: op 000000, rs/rt/rd, func 100011.
- JR: op 000000, rs, rt = rd = 0, func 001000.
- JALR: op 000000, rs, rd, rt = 0, func 001001.
- ORI / ADDI / LW / SW / BEQ: op 001101 / 001000 / 100011 / 101011 / 000100; rs, rt, imm.
- LUI: op 001111, rs = 0, rt, imm.
- JAL / J: op 000011 / 000010, target.

Per accepted beat:
- Legal mnemonic: on the next cycle im_we = 1, im_addr = BASE_PC + 4*count (count sampled at accept), im_wdata = encoded word. count increments in that same cycle.
- Illegal mnemonic: the beat is consumed, nothing is written, count is unchanged, and err is set. err holds until the next start or reset.

Arithmetic:
- count saturates at DEPTH, and full blocks further beats.
- There is no wrap-around.
- im_addr is computed in 32 bits.

## Timing
Reset values:
- state IDLE.
- in_ready 0, im_we 0, im_addr 0, im_wdata 0.
- count 0, full 0, busy 0, err 0.

Write timing:
- Accept-to-write latency is exactly 1 cycle; im_we is registered.
- Back-to-back beats produce im_we on consecutive cycles with addresses incrementing by 4.
- im_addr and im_wdata hold their last values when im_we = 0.

full:
- full is asserted in the cycle count reaches DEPTH, and in_ready drops in that same cycle.
- The DEPTH-th word is still written.

finish:
- finish with in_valid in the same cycle: the beat is not accepted (in_ready = 0), and the state is DONE next cycle.
- A write from a beat accepted in the previous cycle still completes while in DONE.

reset:
- reset mid-session overrides everything; the outputs take their reset values next cycle.
- A pending write is dropped.

start and finish together in IDLE: start wins, and finish is ignored.

## Test plan
- reset, start, then one beat ADDU rs=1 rt=2 rd=3 -> the next cycle shows im_we=1, im_addr=0x00003000, im_wdata=0x00221821, and count=1.
- Back-to-back beats ORI rt=1 imm=0x1234, LUI rt=2 imm=0xFFFF, SW rs=5 rt=4 imm=8, BEQ rs=1 rt=2 imm=0xFFFF -> words 0x34011234, 0x3C02FFFF, 0xACA40008, 0x1022FFFF at addresses 0x3000, 0x3004, 0x3008, 0x300C on 4 consecutive cycles.
- JAL target=0x0000C00 then JR rs=31 -> 0x0C000C00 then 0x03E00008. JALR rs=4 rd=31 -> 0x0080F809.
- mnem=13 between two legal beats -> the illegal beat produces no write, err=1, count advances only for the legal beats, and the second legal word lands at 0x3004. The next start clears err.
- DEPTH=4 with 6 beats offered -> 4 writes, full=1, in_ready=0 after the 4th accept, and beats 5-6 stall.
- reset asserted the cycle after an accept -> no im_we the next cycle and all outputs at reset values. finish together with in_valid -> the beat is not taken and the state is DONE.
